delay_var: RTL and testbench
============================

DELAY_VAR -- requirements
Module: delay_var

Interface
REQ-001 Parameter BIT_WIDTH, default 8: data word width; SHALL be >= 1.
REQ-002 Parameter MAX_LATENCY, default 16: largest supported delay in enabled cycles; SHALL be >= 2.
REQ-003 Parameter LAT_W, default log2(MAX_LATENCY+1): width of the latency port.
REQ-004 clock  in  1  sole clock; all state changes on its rising edge.
REQ-005 n_rst  in  1  asynchronous, active-low reset.
REQ-006 en  in  1  advance enable; 0 = stall, all state held.
REQ-007 flush  in  1  synchronous clear of all in-flight valid flags.
REQ-008 latency  in  LAT_W  requested delay, in enabled cycles.
REQ-009 in_valid  in  1  qualifies in_data.
REQ-010 in_data  in  BIT_WIDTH  sample to delay.
REQ-011 out_valid  out  1  qualifies out_data.
REQ-012 out_data  out  BIT_WIDTH  delayed sample, registered.
REQ-013 primed  out  1  high once L enabled cycles have passed since the last reset, flush or latency change.

Function
REQ-014 Effective latency L: latency clamped; 0 -> 1; > MAX_LATENCY -> MAX_LATENCY.
REQ-015 L is registered as lat_r on each enabled edge; lat_r resets to MAX_LATENCY.
REQ-016 Delay counts en=1 edges only; a sample accepted on enabled edge k appears on out_data/out_valid right after enabled edge k+L-1; L=1 equals a single register.
REQ-017 en=0: out_data, out_valid, primed, ring contents and pointer all hold; flush and latency ignored.
REQ-018 Storage: ring of MAX_LATENCY entries of {valid, data}; write pointer advances mod MAX_LATENCY per enabled edge; read offset derived from lat_r.
REQ-019 Pointer wrap-around from MAX_LATENCY-1 to 0 SHALL cause no glitch, skip or repeat in the output sequence.
REQ-020 Latency change (clamped L != lat_r on an enabled edge): all stored valid flags cleared; out_valid 0 from the next edge until the first sample accepted after the change has traversed the new L; primed drops to 0.
REQ-021 flush=1 with en=1: same clearing as REQ-020; the in_valid on that same edge is discarded.
REQ-022 Flush and latency change on the same edge: treated as one clear; no double effect.
REQ-023 out_data is don't-care when out_valid=0, but SHALL never be X after reset.
REQ-024 primed: counter saturating at L, incremented per enabled edge, zeroed by reset/flush/latency change; primed = (count == L).

Reset
REQ-025 While n_rst=0: out_valid=0, out_data=0, primed=0, write pointer=0, all ring valid flags=0, lat_r=MAX_LATENCY.
REQ-026 Assertion is immediate (asynchronous); release is observed on the first rising clock edge after deassertion.
REQ-027 Ring data bits SHALL NOT require reset, so RAM inference remains possible; valid flags SHALL be reset.
REQ-028 Reset mid-stream drops all in-flight samples; nothing emerges after release.

Structure
REQ-029 The log2 width function and the clamp rule go in the shared common include; they SHALL NOT be redefined locally.
REQ-030 One sub-module, delay_var_ram: simple dual-port ring, one clock, registered read, no reset on data.
REQ-031 Valid flags stay in the top module as a register vector, so flush is single-cycle.

Verification
REQ-032 L=4, en=1, in_data=1,2,3,... all valid -> out_data 1 appears right after the 4th edge, then one value per cycle; primed high from that edge onward.
REQ-033 L=3, en toggling 1,0,1,0 -> output advances only on en=1 edges; values are identical to the en=1-only run.
REQ-034 L=5 streaming, latency changes to 2 at edge 20 -> out_valid 0 for 2 edges, then post-change samples in order; no pre-change sample ever emerges.
REQ-035 latency=0 -> behaves as L=1; latency=MAX_LATENCY+3 -> behaves as MAX_LATENCY; run 3*MAX_LATENCY cycles to cover pointer wrap.
REQ-036 Flush at edge 10 with L=6 -> out_valid 0 for the next 6 edges; the sample presented with flush is never output.
REQ-037 n_rst pulsed low mid-cycle during streaming -> outputs 0 immediately; after release, no stale samples appear.

Source files
------------

// File: rtl/delay_var_pkg.sv
// Shared helpers for the variable-latency delay line.
//   clog2_f   : ceiling log2, never below 1 (usable as a port/array width)
//   clamp_lat : maps a requested latency onto the supported range 1..max_lat
package delay_var_pkg;

  // Smallest r >= 1 with 2**r >= v.
  function automatic int unsigned clog2_f(input int unsigned v);
    int unsigned r = 1;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  // Zero requests mean "one register"; oversize requests saturate at the ring depth.
  function automatic int unsigned clamp_lat(input int unsigned lat, input int unsigned max_lat);
    if (lat == 0) return 1;
    if (lat > max_lat) return max_lat;
    return lat;
  endfunction

endpackage

// File: rtl/delay_var_ram.sv
// Simple dual-port ring storage with registered, write-first read.
//   clock, n_rst : clock; async reset of the read register only (array is not reset)
//   we_i, waddr_i, wdata_i : write port
//   re_i, raddr_i          : read enable/address; rdata_o updates only when re_i=1
//   rdata_o                : registered read data
module delay_var_ram #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clock,
  input  logic          n_rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] rdata_d;

  // Storage array, no reset so it can map onto RAM.
  always_ff @(posedge clock) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Same-address read returns the word being written (needed for latency 1).
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) rdata_d = (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
  end

  // Read register is reset and only loads valid words, so it never carries X.
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/delay_var.sv
// Variable-latency delay line: samples re-emerge L enabled cycles after acceptance.
//   clock, n_rst        : clock, async active-low reset
//   en                  : advance enable (0 holds everything)
//   flush               : synchronous clear of in-flight samples
//   latency             : requested delay, clamped to 1..MAX_LATENCY
//   in_valid, in_data   : input sample
//   out_valid, out_data : delayed sample (registered)
//   primed              : L enabled cycles elapsed since last reset/flush/latency change
module delay_var
  import delay_var_pkg::*;
#(
  parameter int unsigned BIT_WIDTH   = 8,
  parameter int unsigned MAX_LATENCY = 16,
  parameter int unsigned LAT_W       = clog2_f(MAX_LATENCY + 1)
) (
  input  logic                 clock,
  input  logic                 n_rst,
  input  logic                 en,
  input  logic                 flush,
  input  logic [LAT_W-1:0]     latency,
  input  logic                 in_valid,
  input  logic [BIT_WIDTH-1:0] in_data,
  output logic                 out_valid,
  output logic [BIT_WIDTH-1:0] out_data,
  output logic                 primed
);

  localparam int unsigned AW = clog2_f(MAX_LATENCY);
  localparam int unsigned SW = AW + 1;

  logic [LAT_W-1:0]       lat_r_q, lat_r_d;
  logic [AW-1:0]          wp_q, wp_d;
  logic [MAX_LATENCY-1:0] vld_q, vld_d;
  logic                   out_valid_q, out_valid_d;
  logic [LAT_W-1:0]       cnt_q, cnt_d;
  logic                   primed_q, primed_d;

  logic [LAT_W-1:0] lat_eff_c;
  logic             clr_c;
  logic [SW-1:0]    rsum_c;
  logic [AW-1:0]    raddr_c;
  logic             sel_vld_c;
  logic             ram_we_c;
  logic             ram_re_c;

  // Effective latency and the single clear condition (flush and/or latency change).
  always_comb begin
    lat_eff_c = LAT_W'(clamp_lat(32'(latency), MAX_LATENCY));
    clr_c     = en & (flush | (lat_eff_c != lat_r_q));
  end

  // Read slot is L-1 entries behind the write pointer; L=1 reads the slot being written.
  always_comb begin
    rsum_c    = {1'b0, wp_q} + SW'(MAX_LATENCY + 1) - SW'(lat_r_q);
    raddr_c   = (rsum_c >= SW'(MAX_LATENCY)) ? AW'(rsum_c - SW'(MAX_LATENCY)) : AW'(rsum_c);
    sel_vld_c = (raddr_c == wp_q) ? in_valid : vld_q[raddr_c];
    ram_we_c  = en & ~clr_c & in_valid;
    ram_re_c  = en & ~clr_c & sel_vld_c;
  end

  // Next-state for pointer, valid flags, output valid and priming counter.
  always_comb begin
    lat_r_d     = lat_r_q;
    wp_d        = wp_q;
    vld_d       = vld_q;
    out_valid_d = out_valid_q;
    cnt_d       = cnt_q;
    primed_d    = primed_q;
    if (en) begin
      lat_r_d = lat_eff_c;
      wp_d    = (wp_q == AW'(MAX_LATENCY - 1)) ? '0 : wp_q + AW'(1);
      if (clr_c) begin
        // The sample presented on a clearing edge is dropped.
        vld_d       = '0;
        out_valid_d = 1'b0;
        cnt_d       = '0;
        primed_d    = 1'b0;
      end else begin
        vld_d[wp_q] = in_valid;
        out_valid_d = sel_vld_c;
        cnt_d       = (cnt_q == lat_r_q) ? cnt_q : cnt_q + LAT_W'(1);
        primed_d    = (cnt_d == lat_r_q);
      end
    end
  end

  // State registers.
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      lat_r_q     <= LAT_W'(MAX_LATENCY);
      wp_q        <= '0;
      vld_q       <= '0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
      primed_q    <= 1'b0;
    end else begin
      lat_r_q     <= lat_r_d;
      wp_q        <= wp_d;
      vld_q       <= vld_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
      primed_q    <= primed_d;
    end
  end

  delay_var_ram #(
    .DW    (BIT_WIDTH),
    .DEPTH (MAX_LATENCY),
    .AW    (AW)
  ) u_ram (
    .clock   (clock),
    .n_rst   (n_rst),
    .we_i    (ram_we_c),
    .waddr_i (wp_q),
    .wdata_i (in_data),
    .re_i    (ram_re_c),
    .raddr_i (raddr_c),
    .rdata_o (out_data)
  );

  assign out_valid = out_valid_q;
  assign primed    = primed_q;

endmodule

// File: tb/tb_delay_var.sv
module tb_delay_var;

  localparam int BW   = 8;
  localparam int MAXL = 16;
  localparam int LW   = 5;

  logic          clock = 1'b0;
  logic          n_rst;
  logic          en;
  logic          flush;
  logic [LW-1:0] latency;
  logic          in_valid;
  logic [BW-1:0] in_data;
  logic          out_valid;
  logic [BW-1:0] out_data;
  logic          primed;

  always #5 clock = ~clock;

  delay_var #(
    .BIT_WIDTH   (BW),
    .MAX_LATENCY (MAXL),
    .LAT_W       (LW)
  ) dut (
    .clock     (clock),
    .n_rst     (n_rst),
    .en        (en),
    .flush     (flush),
    .latency   (latency),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .primed    (primed)
  );

  // Behavioural model: history of accepted samples since the last clear, newest first.
  bit            hv[$];
  logic [BW-1:0] hd[$];
  int            m_lat;
  int            m_cnt;
  bit            m_ov;
  logic [BW-1:0] m_od;
  bit            m_pr;

  int n_chk  = 0;
  int n_pass = 0;

  function automatic int clamp_l(input int l);
    if (l == 0) return 1;
    if (l > MAXL) return MAXL;
    return l;
  endfunction

  task automatic model_reset();
    hv.delete();
    hd.delete();
    m_lat = MAXL;
    m_cnt = 0;
    m_ov  = 0;
    m_od  = '0;
    m_pr  = 0;
  endtask

  task automatic model_step(input bit e, input bit f, input int lat, input bit iv, input logic [BW-1:0] id);
    int l;
    if (!e) return;
    l = clamp_l(lat);
    if (f || l != m_lat) begin
      m_lat = l;
      hv.delete();
      hd.delete();
      m_ov  = 0;
      m_cnt = 0;
      m_pr  = 0;
    end else begin
      hv.push_front(iv);
      hd.push_front(id);
      if (hv.size() > MAXL) begin
        void'(hv.pop_back());
        void'(hd.pop_back());
      end
      if (hv.size() >= l && hv[l-1]) begin
        m_ov = 1;
        m_od = hd[l-1];
      end else begin
        m_ov = 0;
      end
      if (m_cnt < l) m_cnt++;
      m_pr = (m_cnt == l);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Per-cycle comparison of the DUT against the model.
  task automatic compare();
    chk("out_valid", int'(out_valid), int'(m_ov));
    chk("primed", int'(primed), int'(m_pr));
    if (m_ov) chk("out_data", int'(out_data), int'(m_od));
  endtask

  // Drive one cycle (called from the negedge phase), step model on posedge, check at negedge.
  task automatic run_cycle(input bit e, input bit f, input int lat, input bit iv, input logic [BW-1:0] id);
    en       = e;
    flush    = f;
    latency  = LW'(lat);
    in_valid = iv;
    in_data  = id;
    @(posedge clock);
    model_step(e, f, lat, iv, id);
    @(negedge clock);
    compare();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ov"}, int'(out_valid), 0);
    chk({tag, "_od"}, int'(out_data), 0);
    chk({tag, "_pr"}, int'(primed), 0);
  endtask

  // Asynchronous reset pulse asserted mid-cycle, held across one rising edge.
  task automatic reset_pulse();
    #2 n_rst = 1'b0;
    #1 check_reset_vals("rst_imm");
    model_reset();
    @(posedge clock);
    @(negedge clock);
    n_rst = 1'b1;
    check_reset_vals("rst_rel");
  endtask

  int cur_lat;

  initial begin
    n_rst    = 1'b0;
    en       = 1'b0;
    flush    = 1'b0;
    latency  = '0;
    in_valid = 1'b0;
    in_data  = '0;
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_reset_vals("por");
    n_rst = 1'b1;

    // L=4 streaming: first sample out after the 4th edge, primed from then on.
    run_cycle(1, 0, 4, 0, 0);
    for (int i = 1; i <= 6; i++) begin
      run_cycle(1, 0, 4, 1, BW'(i));
      if (i == 3) chk("l4_not_yet", int'(out_valid), 0);
      if (i == 4) begin
        chk("l4_first_v", int'(out_valid), 1);
        chk("l4_first_d", int'(out_data), 1);
        chk("l4_primed", int'(primed), 1);
      end
      if (i == 6) chk("l4_third_d", int'(out_data), 3);
    end

    // L=5 stream, switch to L=2 on edge 20: two empty edges, then sample 21.
    run_cycle(1, 0, 5, 0, 0);
    for (int i = 1; i <= 24; i++) begin
      run_cycle(1, 0, (i >= 20) ? 2 : 5, 1, BW'(i));
      if (i == 20 || i == 21) chk("lchg_gap", int'(out_valid), 0);
      if (i == 22) begin
        chk("lchg_v", int'(out_valid), 1);
        chk("lchg_d", int'(out_data), 21);
      end
    end

    // L=6 flush: flush edge plus five more empty, then first post-flush sample.
    run_cycle(1, 0, 6, 0, 0);
    for (int i = 1; i <= 10; i++) run_cycle(1, 0, 6, 1, BW'(i));
    run_cycle(1, 1, 6, 1, 8'hAA);
    chk("flush_edge", int'(out_valid), 0);
    for (int i = 0; i < 8; i++) begin
      run_cycle(1, 0, 6, 1, BW'(100 + i));
      if (i < 5) chk("flush_gap", int'(out_valid), 0);
      if (i == 5) begin
        chk("flush_v", int'(out_valid), 1);
        chk("flush_d", int'(out_data), 100);
      end
    end

    // L=3 with en toggling.
    for (int i = 0; i < 30; i++) run_cycle(i[0] == 1'b0, 0, 3, 1, BW'(50 + i));

    // Clamp boundaries with pointer wrap.
    for (int i = 0; i < 3 * MAXL + 4; i++) run_cycle(1, 0, 0, 1, BW'($urandom));
    for (int i = 0; i < 3 * MAXL + 4; i++) run_cycle(1, 0, MAXL + 3, 1, BW'($urandom));

    // Reset mid-stream.
    reset_pulse();
    for (int i = 0; i < 40; i++) run_cycle(1, 0, 7, 1, BW'($urandom));
    reset_pulse();

    // Randomized traffic.
    cur_lat = 4;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) < 2) cur_lat = int'($urandom_range(MAXL + 3));
      run_cycle($urandom_range(99) < 75, $urandom_range(99) < 3, cur_lat,
                $urandom_range(99) < 70, BW'($urandom));
      if ($urandom_range(999) == 0) reset_pulse();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
